// File: rtl/axil_cmd_master.sv
// AXI4-Lite single-outstanding master driven by a valid/ready command port.
// Returns one response per command with data, RESP and handshake latency.
module axil_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int LAT_WIDTH          = 16
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [LAT_WIDTH-1:0]            rsp_cycles,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, WR, WB, RA, RD, RSP
  } state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;
  logic [LAT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic [LAT_WIDTH-1:0] rsp_cycles_q, rsp_cycles_d;
  logic [7:0]          err_count_q, err_count_d, err_inc;
  logic                aw_fin, w_fin;

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_write_d  = rsp_write_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_resp_d   = rsp_resp_q;
    rsp_cycles_d = rsp_cycles_q;
    err_count_d  = err_count_q;

    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LAT_WIDTH'(1);
    err_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    aw_fin  = !awvalid_q || M_AXI_AWREADY;
    w_fin   = !wvalid_q || M_AXI_WREADY;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr & ~AW'(3);
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          rsp_write_d = cmd_write;
          cnt_d       = '0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RA;
          end
        end
      end
      WR: begin
        cnt_d = cnt_inc;
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        // B is only taken once both address and data have left
        if (aw_fin && w_fin) state_d = WB;
      end
      WB: begin
        cnt_d = cnt_inc;
        if (M_AXI_BVALID) begin
          bready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = '0;
          rsp_resp_d   = M_AXI_BRESP;
          rsp_cycles_d = cnt_inc;
          if (M_AXI_BRESP != 2'b00) err_count_d = err_inc;
          state_d      = RSP;
        end
      end
      RA: begin
        cnt_d = cnt_inc;
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD;
        end
      end
      RD: begin
        cnt_d = cnt_inc;
        if (M_AXI_RVALID) begin
          rready_d     = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = M_AXI_RDATA;
          rsp_resp_d   = M_AXI_RRESP;
          rsp_cycles_d = cnt_inc;
          if (M_AXI_RRESP != 2'b00) err_count_d = err_inc;
          state_d      = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= '0;
      rsp_cycles_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_resp_q   <= rsp_resp_d;
      rsp_cycles_q <= rsp_cycles_d;
      err_count_q  <= err_count_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_cycles    = rsp_cycles_q;
  assign err_count     = err_count_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master against a small AXI-Lite register file.
// Slave AWREADY delay, RRESP code and R stall are steerable from the stimulus.
module tb_axil_cmd_master;

  localparam int AW = 40;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [LW-1:0] rsp_cycles;
  logic [7:0]    err_count;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axil_cmd_master dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .rsp_cycles   (rsp_cycles),
    .err_count    (err_count),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  // slave model
  int            aw_delay = 0;
  logic [1:0]    rresp_cfg = 2'b00;
  logic          r_hold = 1'b0;
  int            aw_cnt, b_count;
  logic          aw_got, w_got, ar_got;
  logic [AW-1:0] aw_a, ar_a, wa, ra;
  logic [31:0]   w_d, wd;
  logic [3:0]    w_s, ws;
  logic [31:0]   regs [16];
  logic          aw_hs, w_hs, ar_hs;

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid;
  assign arready = arvalid;
  assign bresp   = 2'b00;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign wa      = aw_hs ? awaddr : aw_a;
  assign wd      = w_hs ? wdata : w_d;
  assign ws      = w_hs ? wstrb : w_s;
  assign ra      = ar_hs ? araddr : ar_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; b_count <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_a <= '0; ar_a <= '0; w_d <= '0; w_s <= '0;
      bvalid <= 1'b0; rvalid <= 1'b0;
      rdata <= '0; rresp <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[0] <= 32'hdeadbeef;
      regs[1] <= 32'h76543210;
    end else begin
      if (aw_hs) begin
        aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_hs) begin
        w_got <= 1'b1; w_d <= wdata; w_s <= wstrb;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_count <= b_count + 1;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid) begin
        bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
        for (int b = 0; b < 4; b++)
          if (ws[b]) regs[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
      end
      if (ar_hs) begin
        ar_got <= 1'b1; ar_a <= araddr;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if ((ar_got || ar_hs) && !rvalid && !r_hold) begin
        rvalid <= 1'b1; ar_got <= 1'b0;
        rdata <= regs[ra[5:2]]; rresp <= rresp_cfg;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench in the cycle right after the accept edge
  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin
      tick(); n++;
    end
    chk("accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 100) begin
      tick(); cyc++;
    end
    chk("rsp_valid", rsp_valid, 1);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         input logic [31:0] exp);
    int cyc;
    issue(1'b0, a, 32'h0, 4'h0);
    chk({tag, "_araddr"}, araddr, a & ~64'h3);
    wait_rsp(1, cyc);
    chk({tag, "_lat"}, cyc, 3);
    chk({tag, "_rdata"}, rsp_rdata, exp);
    chk({tag, "_resp"}, rsp_resp, 0);
    chk({tag, "_write"}, rsp_write, 0);
    release_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cycles", rsp_cycles, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // zero-wait write
    issue(1'b1, 40'h8, 32'h12345678, 4'hF);
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_bready", bready, 1);
    chk("wr_awaddr", awaddr, 40'h8);
    chk("wr_wdata", wdata, 32'h12345678);
    chk("wr_awprot", awprot, 0);
    chk("wr_cmd_ready", cmd_ready, 0);
    tick();
    chk("wr_no_rsp_early", rsp_valid, 0);
    wait_rsp(2, cyc);
    chk("wr_lat", cyc, 3);
    chk("wr_resp", rsp_resp, 0);
    chk("wr_cycles", rsp_cycles, 2);
    chk("wr_write", rsp_write, 1);
    chk("wr_rdata", rsp_rdata, 0);
    release_rsp();

    do_read("rd08", 40'h8, 32'h12345678);
    chk("rd_cycles", rsp_cycles, 2);
    chk("rd_arprot", arprot, 0);
    do_read("rd00", 40'h0, 32'hdeadbeef);
    do_read("rd07", 40'h7, 32'h76543210);

    // AWREADY three cycles late, WREADY immediate, partial strobes
    aw_delay = 3;
    b0 = b_count;
    issue(1'b1, 40'hC, 32'hA5A5A5A5, 4'h5);
    chk("dly_awvalid1", awvalid, 1);
    chk("dly_wvalid1", wvalid, 1);
    chk("dly_wstrb", wstrb, 4'h5);
    tick();
    chk("dly_wvalid2", wvalid, 0);
    chk("dly_awvalid2", awvalid, 1);
    tick();
    chk("dly_awvalid3", awvalid, 1);
    tick();
    chk("dly_awvalid4", awvalid, 1);
    tick();
    chk("dly_awvalid5", awvalid, 0);
    chk("dly_rsp_early", rsp_valid, 0);
    wait_rsp(5, cyc);
    chk("dly_lat", cyc, 6);
    chk("dly_cycles", rsp_cycles, 5);
    chk("dly_bcount", b_count, b0 + 1);
    chk("dly_bvalid", bvalid, 0);
    release_rsp();
    aw_delay = 0;
    do_read("rd0c", 40'hC, 32'h00A500A5);

    // slave errors
    rresp_cfg = 2'b10;
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    wait_rsp(1, cyc);
    chk("err1_resp", rsp_resp, 2);
    chk("err1_count", err_count, 1);
    release_rsp();
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    wait_rsp(1, cyc);
    chk("err2_resp", rsp_resp, 2);
    chk("err2_count", err_count, 2);
    release_rsp();
    for (int i = 0; i < 298; i++) begin
      issue(1'b0, 40'h0, 32'h0, 4'h0);
      wait_rsp(1, cyc);
      release_rsp();
    end
    chk("err_sat", err_count, 255);
    rresp_cfg = 2'b00;

    // response back-pressure
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    wait_rsp(1, cyc);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 40'h0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h76543210);
      chk("bp_cycles", rsp_cycles, 2);
      chk("bp_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_done", rsp_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);
    chk("bp_no_ar_yet", arvalid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_ar", arvalid, 1);
    chk("bp_next_busy", cmd_ready, 0);
    wait_rsp(1, cyc);
    chk("bp_next_rdata", rsp_rdata, 32'hdeadbeef);
    release_rsp();

    // reset while waiting for R
    r_hold = 1'b1;
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    tick();
    chk("mid_rready", rready, 1);
    chk("mid_rvalid", rvalid, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rready0", rready, 0);
    chk("mid_arvalid0", arvalid, 0);
    chk("mid_cmd_ready0", cmd_ready, 0);
    chk("mid_rsp_valid0", rsp_valid, 0);
    chk("mid_err0", err_count, 0);
    chk("mid_araddr0", araddr, 0);
    r_hold = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mid_ready1", cmd_ready, 1);
    issue(1'b1, 40'h10, 32'h00000055, 4'hF);
    wait_rsp(1, cyc);
    chk("mid_wr_lat", cyc, 3);
    chk("mid_wr_resp", rsp_resp, 0);
    chk("mid_wr_cycles", rsp_cycles, 2);
    release_rsp();
    do_read("rd10", 40'h10, 32'h00000055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
